// File: rtl/dma_read_responder.sv
// DMA read responder: fetches memory words, packs them into beats, and hands each beat to the requester over valid/ready.
// Optional DMA_STRIDE_EN adds a per-beat byte stride (dma_stride) instead of contiguous beat addressing.
`timescale 1ns/1ps

module dma_read_responder #(
  parameter int BEAT_W         = 256,
  parameter int MEM_W          = 32,
  parameter int WORDS_PER_BEAT = 8,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dma_start,
  input  logic [31:0]       dma_addr,
  input  logic [CNT_W-1:0]  dma_beats,
`ifdef DMA_STRIDE_EN
  input  logic [31:0]       dma_stride,
`endif
  output logic              dma_valid,
  input  logic              dma_ready,
  output logic [BEAT_W-1:0] dma_data,
  output logic              dma_done,
  output logic              busy,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int IDX_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS_PER_BEAT - 1);
  localparam logic [31:0]      WORD_BYTES = 32'(MEM_W / 8);
  localparam logic [31:0]      BEAT_BYTES = 32'(WORDS_PER_BEAT * (MEM_W / 8));

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    ZDONE
  } state_t;

  state_t state, state_next;

  logic [31:0]                          word_addr;
  logic [31:0]                          beat_base;
  logic [31:0]                          beat_step;
  logic [CNT_W-1:0]                     beats_lat;
  logic [CNT_W-1:0]                     beat_cnt;
  logic [IDX_W-1:0]                     word_idx;
  logic [WORDS_PER_BEAT-1:0][MEM_W-1:0] lanes;
  logic                                 last_beat;
  logic                                 last_word;
  logic                                 word_xfer;
  logic                                 beat_xfer;

`ifdef DMA_STRIDE_EN
  logic [31:0] stride_lat;
  assign beat_step = stride_lat;
`else
  assign beat_step = BEAT_BYTES;
`endif

  assign last_beat = (beat_cnt == beats_lat - CNT_W'(1));
  assign last_word = (word_idx == LAST_IDX);
  assign word_xfer = mem_req && mem_ack;
  assign beat_xfer = dma_valid && dma_ready;

  assign mem_req   = (state == FETCH);
  assign dma_valid = (state == PRESENT);
  assign dma_done  = ((state == PRESENT) && last_beat) || (state == ZDONE);
  assign busy      = (state != IDLE);
  assign mem_addr  = word_addr;
  assign dma_data  = BEAT_W'(lanes);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dma_start) state_next = (dma_beats == '0) ? ZDONE : FETCH;
      end
      FETCH: begin
        if (word_xfer && last_word) state_next = PRESENT;
      end
      PRESENT: begin
        if (beat_xfer) state_next = last_beat ? IDLE : FETCH;
      end
      ZDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_addr  <= '0;
      beat_base  <= '0;
      beats_lat  <= '0;
      beat_cnt   <= '0;
      word_idx   <= '0;
      lanes      <= '0;
`ifdef DMA_STRIDE_EN
      stride_lat <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dma_start) begin
            word_addr  <= dma_addr & ~32'h3;
            beat_base  <= dma_addr & ~32'h3;
            beats_lat  <= dma_beats;
            beat_cnt   <= '0;
            word_idx   <= '0;
`ifdef DMA_STRIDE_EN
            stride_lat <= dma_stride & ~32'h3;
`endif
          end
        end
        FETCH: begin
          if (word_xfer) begin
            lanes[word_idx] <= mem_rdata;
            word_addr       <= word_addr + WORD_BYTES;
            word_idx        <= last_word ? '0 : word_idx + IDX_W'(1);
          end
        end
        PRESENT: begin
          // Next beat restarts from the beat base, so contiguous and strided modes share one path.
          if (beat_xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (!last_beat) begin
              word_addr <= beat_base + beat_step;
              beat_base <= beat_base + beat_step;
              word_idx  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_responder.sv
// Scoreboard bench for dma_read_responder: stimulus pushes expected words/beats, monitor pops and compares.
`timescale 1ns/1ps

module tb_dma_read_responder;

  localparam int BEAT_W = 256;
  localparam int MEM_W  = 32;
  localparam int WPB    = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              dma_start = 1'b0;
  logic [31:0]       dma_addr = '0;
  logic [CNT_W-1:0]  dma_beats = '0;
  logic              dma_valid;
  logic              dma_ready = 1'b0;
  logic [BEAT_W-1:0] dma_data;
  logic              dma_done;
  logic              busy;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ack = 1'b0;
  logic [MEM_W-1:0]  mem_rdata;
`ifdef DMA_STRIDE_EN
  logic [31:0]       dma_stride = '0;
`endif

  dma_read_responder #(
    .BEAT_W(BEAT_W),
    .MEM_W(MEM_W),
    .WORDS_PER_BEAT(WPB),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .dma_start(dma_start),
    .dma_addr(dma_addr),
    .dma_beats(dma_beats),
`ifdef DMA_STRIDE_EN
    .dma_stride(dma_stride),
`endif
    .dma_valid(dma_valid),
    .dma_ready(dma_ready),
    .dma_data(dma_data),
    .dma_done(dma_done),
    .busy(busy),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory returns the word address as its data.
  assign mem_rdata = mem_addr;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic              done;
    logic              zero;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  int total = 0;
  int bad   = 0;
  int ack_mode   = 0;  // 0 always, 1 random, 2 every third cycle
  int ready_mode = 0;  // 0 always, 1 random, 2 held low

  task automatic check(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: beat n covers words at (base&~3) + n*step + 4k.
  task automatic push_expect(input logic [31:0] base, input int unsigned beats, input logic [31:0] stride);
    logic [31:0] b, st, a;
    exp_t e;
    b = base & ~32'h3;
`ifdef DMA_STRIDE_EN
    st = stride & ~32'h3;
`else
    st = 32'd32;
    if (stride != 0) st = 32'd32;
`endif
    if (beats == 0) begin
      e.data = '0; e.done = 1'b1; e.zero = 1'b1;
      sb_q.push_back(e);
    end
    for (int unsigned n = 0; n < beats; n++) begin
      e.data = '0;
      for (int unsigned k = 0; k < WPB; k++) begin
        a = b + n * st + 4 * k;
        addr_q.push_back(a);
        e.data[k*MEM_W +: MEM_W] = a;
      end
      e.done = (n == beats - 1);
      e.zero = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] base, input int unsigned beats, input logic [31:0] stride);
    @(posedge clk); #1;
    dma_start = 1'b1;
    dma_addr  = base;
    dma_beats = CNT_W'(beats);
`ifdef DMA_STRIDE_EN
    dma_stride = stride;
`endif
    push_expect(base, beats, stride);
    @(posedge clk); #1;
    dma_start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("rst_ctrl", {dma_valid, dma_done, busy, mem_req}, '0);
    check("rst_data", dma_data, '0);
    check("rst_addr", mem_addr, '0);
    sb_q.delete();
    addr_q.delete();
    dma_start = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (!busy && sb_q.size() == 0 && addr_q.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL idle_timeout: got busy=%0b beats_left=%0d words_left=%0d want idle", busy, sb_q.size(), addr_q.size());
    do_reset();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (dma_valid) return;
    end
    total++; bad++;
    $display("FAIL valid_timeout: got dma_valid=%0b want 1", dma_valid);
  endtask

  // Handshake input driver, updated just after each rising edge.
  initial begin
    int ack_ctr;
    ack_ctr = 0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = 1'($urandom_range(0, 1));
        default: begin
          ack_ctr = (ack_ctr + 1) % 3;
          mem_ack = (ack_ctr == 0);
        end
      endcase
      case (ready_mode)
        0: dma_ready = 1'b1;
        1: dma_ready = 1'($urandom_range(0, 1));
        default: dma_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge and retires scoreboard entries.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (mem_req && mem_ack) begin
          if (addr_q.size() == 0) check("mem_unexpected", mem_req, 1'b0);
          else check("mem_addr", mem_addr, addr_q.pop_front());
        end else if (mem_req && addr_q.size() != 0) begin
          check("mem_addr_hold", mem_addr, addr_q[0]);
        end
        if (dma_valid && dma_ready) begin
          if (sb_q.size() == 0) check("beat_unexpected", dma_valid, 1'b0);
          else begin
            e = sb_q.pop_front();
            if (e.zero) check("beat_kind", dma_valid, 1'b0);
            else begin
              check("beat_data", dma_data, e.data);
              check("beat_done", dma_done, e.done);
            end
          end
        end else if (dma_done && !dma_valid) begin
          if (sb_q.size() == 0) check("zdone_unexpected", dma_done, 1'b0);
          else begin
            e = sb_q.pop_front();
            if (!e.zero) check("zdone_spurious", dma_done, 1'b0);
            else check("zdone_mem_idle", mem_req, 1'b0);
          end
        end
      end
    end
  end

  initial begin
    int first, reqc;
    logic [BEAT_W-1:0] exp0;

    repeat (3) @(posedge clk);
    #2;
    check("reset_ctrl", {dma_valid, dma_done, busy, mem_req}, '0);
    check("reset_data", dma_data, '0);
    check("reset_addr", mem_addr, '0);
    rstn = 1'b1;

    // Single beat latency.
    ack_mode = 0; ready_mode = 0;
    @(posedge clk); #1;
    dma_start = 1'b1; dma_addr = 32'h1000_0010; dma_beats = 1;
`ifdef DMA_STRIDE_EN
    dma_stride = 32'h20;
`endif
    push_expect(32'h1000_0010, 1, 32'h20);
    first = -1; reqc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      dma_start = 1'b0;
      if (mem_req) reqc++;
      if (dma_valid && first < 0) first = i;
    end
    check("latency_first_valid", first, 9);
    check("latency_req_cycles", reqc, 8);
    wait_idle(200);

    // Backpressure on beat 0 of two.
    ready_mode = 2;
    issue(32'h1000_0010, 2, 32'h20);
    wait_valid(200);
    exp0 = '0;
    for (int unsigned k = 0; k < WPB; k++) exp0[k*MEM_W +: MEM_W] = 32'h1000_0010 + 4 * k;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", dma_valid, 1'b1);
      check("bp_done", dma_done, 1'b0);
      check("bp_data", dma_data, exp0);
      @(posedge clk); #2;
    end
    ready_mode = 0;
    wait_idle(400);

    // Memory stalls, zero length, address wrap.
    ack_mode = 2;
    issue(32'h1000_0010, 2, 32'h20);
    wait_idle(800);
    ack_mode = 0;
    issue(32'h0000_0100, 0, 32'h20);
    wait_idle(50);
    issue(32'hFFFF_FFF0, 1, 32'h20);
    wait_idle(200);

    // Reset mid-fetch, then restart.
    ack_mode = 2;
    issue(32'h3000_0000, 3, 32'h20);
    repeat (6) @(posedge clk);
    do_reset();
    issue(32'h3000_0000, 2, 32'h20);
    wait_idle(1000);

    // Start pulsed while a beat is presented is ignored.
    ack_mode = 0; ready_mode = 2;
    issue(32'h4000_0000, 2, 32'h20);
    wait_valid(200);
    @(posedge clk); #1;
    dma_start = 1'b1; dma_addr = 32'h5000_0000; dma_beats = 5;
    @(posedge clk); #1;
    dma_start = 1'b0;
    ready_mode = 0;
    wait_idle(400);

`ifdef DMA_STRIDE_EN
    issue(32'h2000_0100, 3, 32'h40);
    wait_idle(400);
`endif

    // Randomized transfers.
    for (int t = 0; t < 30; t++) begin
      ack_mode   = $urandom_range(0, 2);
      ready_mode = $urandom_range(0, 1);
      issue($urandom(), $urandom_range(0, 3), $urandom());
      wait_idle(3000);
    end

    ack_mode = 0; ready_mode = 0;
    repeat (5) @(posedge clk);
    check("final_idle", busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_read_responder.md
Name: dma_read_responder

Overview:
- DMA responder that services the accelerator control block's tile-fetch requests.
- On dma_start it reads 32-bit words from the system memory bus and packs 8 words into each 256-bit beat.
- It presents each beat to the requester with a valid/ready handshake and flags the last beat with dma_done.
- It sits between the accelerator control register block and the SoC memory read port.

Parameters:
- BEAT_W, 256, width of dma_data. Must equal WORDS_PER_BEAT*MEM_W.
- MEM_W, 32, memory bus data width.
- WORDS_PER_BEAT, 8, memory words packed per beat.
- CNT_W, 16, width of the beat-count input and internal counters.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rstn, input, 1, asynchronous active-low reset.
- dma_start, input, 1, request pulse; sampled only in IDLE.
- dma_addr, input, 32, byte base address; bits [1:0] are ignored (treated as 0).
- dma_beats, input, CNT_W, number of 256-bit beats to deliver.
- dma_valid, output, 1, dma_data holds a valid beat.
- dma_ready, input, 1, requester accepts the beat.
- dma_data, output, BEAT_W, packed beat.
- dma_done, output, 1, marks the final beat, or the zero-length completion.
- busy, output, 1, high whenever state is not IDLE.
- mem_req, output, 1, memory read request.
- mem_addr, output, 32, word-aligned read address.
- mem_ack, input, 1, read data valid this cycle.
- mem_rdata, input, MEM_W, read data.

Behaviour:
- Reset (async, rstn=0): state IDLE. The following outputs all go to 0: dma_valid, dma_done, dma_data, busy, mem_req, mem_addr. All internal counters clear. Reset mid-transfer aborts immediately with no done pulse.
- States: IDLE, FETCH, PRESENT, ZDONE.
- IDLE:
  - On dma_start=1, latch the address as {dma_addr[31:2],2'b00} and latch dma_beats.
  - If beats!=0, go to FETCH; if beats==0, go to ZDONE.
  - dma_start in any other state is ignored.
- FETCH:
  - mem_req=1 and mem_addr=current word address.
  - A word transfers on a cycle where mem_req&&mem_ack. On transfer:
    - write mem_rdata into lane word_idx, i.e. bits [MEM_W*word_idx +: MEM_W]; word 0 is in the LSBs;
    - word address += 4, wrapping mod 2^32;
    - word_idx increments.
  - mem_addr is held stable while waiting for ack.
  - After the 8th word transfers, drop mem_req and go to PRESENT next cycle.
  - There is no prefetch during PRESENT.
- PRESENT:
  - dma_valid=1. dma_data and dma_done stay stable until the handshake.
  - dma_done=1 only when the current beat is the last, i.e. beat_cnt==latched beats-1.
  - On dma_valid&&dma_ready: increment beat_cnt. If it was the last beat, go to IDLE with dma_valid and dma_done cleared next cycle; otherwise return to FETCH with word_idx=0.
  - dma_ready while dma_valid=0 has no effect.
- ZDONE: dma_done=1 and dma_valid=0 for exactly one cycle, then IDLE.
- Latency with mem_ack tied 1:
  - start sampled at cycle 0;
  - mem_req high cycles 1..8;
  - dma_valid first high at cycle 9;
  - each later beat follows 9 cycles after the previous accept.
- Beat address sequence (contiguous mode): beat n starts at base+32*n, with 32-bit wrap.
- busy is high from the cycle after start is accepted until the state returns to IDLE.

Optional Feature:
- Macro: DMA_STRIDE_EN.
- When defined:
  - add input dma_stride (32 bits, byte units), latched with dma_start;
  - beat n starts at base+n*stride, using modulo 2^32 addition, with stride bits [1:0] forced to 0;
  - words within a beat remain contiguous.
  - This supports fetching one row of a matrix tile per beat.
- When not defined: the port is absent and addressing is contiguous as above.

Test Plan:
- Single beat: rstn released; dma_addr=0x1000_0010, dma_beats=1; memory returns addr as data; mem_ack=1; dma_ready=1.
  -> mem_addr 0x1000_0010..0x1000_002C;
  -> dma_valid at cycle 9 with dma_done=1;
  -> dma_data word k = 0x1000_0010+4k.
- Backpressure: beats=2, dma_ready held 0 for 5 cycles on beat 0.
  -> dma_valid, dma_data and dma_done (0) hold stable;
  -> beat 1 starts at 0x1000_0030 after the accept;
  -> dma_done=1 only on beat 1.
- Memory stalls: mem_ack pulses every third cycle.
  -> mem_addr is held during waits;
  -> packing order is unchanged;
  -> no beat is presented before its 8th word.
- Zero length and wrap: beats=0 -> one-cycle dma_done with dma_valid=0, no mem_req; addr=0xFFFF_FFF0, beats=1 -> mem_addr wraps 0xFFFF_FFFC -> 0x0000_0000.
- Abort and ignored start: rstn=0 mid-FETCH -> all outputs 0 immediately; a restart completes correctly; dma_start pulsed during PRESENT is ignored.
- DMA_STRIDE_EN: base=0x2000_0100, stride=0x40, beats=3 -> beats start at 0x2000_0100, 0x2000_0140, 0x2000_0180.
